// File: rtl/loop_nest_pkg.sv
// Shared types and defaults for the nested-loop index iterator.
// Holds the two-state FSM encoding and the default loop depth/width.
package loop_nest_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [N_DEF-1:0][W_DEF-1:0] idx_vec_t;

endpackage

// File: rtl/loop_nest_counter_level.sv
// One loop level: an index counter that wraps to 0 after reaching its
// inclusive maximum, and reports when it is sitting at that maximum.
module loop_level
#(
    parameter int W = 8
)
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         step,
    input  logic [W-1:0] max,
    output logic [W-1:0] idx,
    output logic         at_max
);

    logic [W-1:0] idx_q;
    logic [W-1:0] idx_d;

    assign at_max = (idx_q == max);
    assign idx    = idx_q;

    // Clear wins over step so an abort or a new run never leaks a partial advance.
    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (step) begin
            idx_d = at_max ? '0 : idx_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/loop_nest_counter.sv
// Nested-loop iterator: N cascaded loop_level counters, innermost level 0.
// Optional abort input is enabled by defining LOOP_NEST_COUNTER_ABORT_EN.
module loop_nest_counter
    import loop_nest_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
)
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [N-1:0][W-1:0] cfg_max,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0][W-1:0] out_idx,
    output logic [N-1:0]        out_last
`ifdef LOOP_NEST_COUNTER_ABORT_EN
    ,
    input  logic                abort
`endif
);

    state_e                state_q;
    state_e                state_d;
    logic [N-1:0][W-1:0]   max_q;
    logic [N-1:0][W-1:0]   max_d;
    logic [N-1:0]          atMax;
    logic [N-1:0]          lowMax;
    logic [N-1:0]          step;
    logic                  cfgAccept;
    logic                  transfer;
    logic                  finalBeat;
    logic                  abortRun;
    logic                  clearIdx;

    assign cfg_ready = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign cfgAccept = cfg_valid && cfg_ready;
    assign transfer  = out_valid && out_ready;

`ifdef LOOP_NEST_COUNTER_ABORT_EN
    assign abortRun = abort && (state_q == RUN);
`else
    assign abortRun = 1'b0;
`endif

    // lowMax[i]: levels 0..i all at max; step[i]: carry into level i.
    always_comb begin
        lowMax    = '0;
        step      = '0;
        lowMax[0] = atMax[0];
        step[0]   = transfer;
        for (int i = 1; i < N; i++) begin
            lowMax[i] = lowMax[i-1] && atMax[i];
            step[i]   = step[i-1] && atMax[i-1];
        end
    end

    assign finalBeat = transfer && lowMax[N-1];
    assign clearIdx  = cfgAccept || finalBeat || abortRun;
    assign out_last  = out_valid ? lowMax : '0;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d = RUN;
                    max_d   = cfg_max;
                end
            end
            RUN: begin
                if (abortRun || finalBeat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : gen_level
        loop_level #(.W(W)) u_level (
            .clk    (clk),
            .rstn   (rstn),
            .clear  (clearIdx),
            .step   (step[g]),
            .max    (max_q[g]),
            .idx    (out_idx[g]),
            .at_max (atMax[g])
        );
    end

endmodule

// File: tb/tb_loop_nest_counter.sv
// Scoreboard bench for loop_nest_counter with N=3, W=8; abort cases are
// exercised only when LOOP_NEST_COUNTER_ABORT_EN is defined.
module tb_loop_nest_counter;

    localparam int TN = 3;
    localparam int TW = 8;

    typedef struct packed {
        logic [TN*TW-1:0] idx;
        logic [TN-1:0]    last;
    } beat_t;

    logic                  clk;
    logic                  rstn;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [TN-1:0][TW-1:0] cfg_max;
    logic                  out_valid;
    logic                  out_ready;
    logic [TN-1:0][TW-1:0] out_idx;
    logic [TN-1:0]         out_last;
`ifdef LOOP_NEST_COUNTER_ABORT_EN
    logic                  abort;
`endif

    beat_t sbQ[$];
    int    compared      = 0;
    int    mismatched    = 0;
    int    transferCount = 0;

    loop_nest_counter #(.N(TN), .W(TW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_max   (cfg_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef LOOP_NEST_COUNTER_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference loop nest: expected beats in iteration order, optionally truncated.
    task automatic pushSequence(input logic [TN-1:0][TW-1:0] mx, input int limit);
        int    pushed;
        beat_t b;
        pushed = 0;
        for (int a = 0; a <= int'(mx[2]); a++) begin
            for (int m = 0; m <= int'(mx[1]); m++) begin
                for (int z = 0; z <= int'(mx[0]); z++) begin
                    if (limit == 0 || pushed < limit) begin
                        b.idx     = {a[TW-1:0], m[TW-1:0], z[TW-1:0]};
                        b.last[0] = (z == int'(mx[0]));
                        b.last[1] = b.last[0] && (m == int'(mx[1]));
                        b.last[2] = b.last[1] && (a == int'(mx[2]));
                        sbQ.push_back(b);
                        pushed++;
                    end
                end
            end
        end
    endtask

    // Presents one config beat from an idle state and checks the first-beat latency.
    task automatic applyStimulus(input logic [TN-1:0][TW-1:0] mx);
        cfg_max   = mx;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        checkOutput("latency_out_valid", 64'(out_valid), 64'd1);
        checkOutput("latency_cfg_ready", 64'(cfg_ready), 64'd0);
    endtask

    // Drives out_ready until the scoreboard drains, then checks the return to idle.
    task automatic drainRun(input int readyPct, input int expBeats, input bit noisyCfg, input string tag);
        int  startCount;
        bit  done;
        startCount = transferCount;
        done       = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            out_ready = ($urandom_range(0, 99) < readyPct);
            if (noisyCfg && sbQ.size() > 3) begin
                cfg_valid = $urandom_range(0, 1) == 1;
                cfg_max   = '0;
            end else begin
                cfg_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            done = (sbQ.size() == 0);
        end
        out_ready = 1'b0;
        cfg_valid = 1'b0;
        checkOutput({tag, "_beats"}, 64'(transferCount - startCount), 64'(expBeats));
        checkOutput({tag, "_cfg_ready_after"}, 64'(cfg_ready), 64'd1);
        checkOutput({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_out_last_idle"}, 64'(out_last), 64'd0);
    endtask

    // Monitor: compares every presented beat against the queue head; pops on transfer.
    always @(negedge clk) begin
        if (rstn && out_valid) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_beat", 64'(out_idx), 64'hFFFF_FFFF);
            end else begin
                checkOutput("out_idx", 64'(out_idx), 64'(sbQ[0].idx));
                checkOutput("out_last", 64'(out_last), 64'(sbQ[0].last));
                if (out_ready) begin
                    void'(sbQ.pop_front());
                    transferCount++;
                end
            end
        end
    end

    initial begin
        bit stopped;
        rstn      = 1'b0;
        cfg_valid = 1'b0;
        cfg_max   = '0;
        out_ready = 1'b0;
`ifdef LOOP_NEST_COUNTER_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("reset_out_last", 64'(out_last), 64'd0);
        checkOutput("reset_out_idx", 64'(out_idx), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] full-rate run, max {1,2,3}");
        pushSequence({8'd1, 8'd2, 8'd3}, 0);
        applyStimulus({8'd1, 8'd2, 8'd3});
        drainRun(100, 24, 1'b0, "full_rate");

        $display("[TB] stalled run with cfg noise, max {1,2,3}");
        pushSequence({8'd1, 8'd2, 8'd3}, 0);
        applyStimulus({8'd1, 8'd2, 8'd3});
        drainRun(20, 24, 1'b1, "stalled");

        $display("[TB] all-zero max");
        pushSequence({8'd0, 8'd0, 8'd0}, 0);
        applyStimulus({8'd0, 8'd0, 8'd0});
        drainRun(100, 1, 1'b0, "all_zero");

        $display("[TB] innermost max 255");
        pushSequence({8'd0, 8'd0, 8'd255}, 0);
        applyStimulus({8'd0, 8'd0, 8'd255});
        drainRun(100, 256, 1'b0, "wide_inner");

        $display("[TB] reset after beat 7");
        pushSequence({8'd1, 8'd2, 8'd3}, 0);
        applyStimulus({8'd1, 8'd2, 8'd3});
        out_ready = 1'b1;
        stopped   = 1'b0;
        for (int c = 0; c < 100 && !stopped; c++) begin
            @(posedge clk);
            #1;
            stopped = (transferCount % 1000 != 0) && (sbQ.size() == 24 - 7);
        end
        checkOutput("reset_mid_beats_left", 64'(sbQ.size()), 64'd17);
        out_ready = 1'b0;
        rstn      = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sbQ.delete();
        checkOutput("reset_mid_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_mid_cfg_ready", 64'(cfg_ready), 64'd1);
        pushSequence({8'd0, 8'd1, 8'd2}, 0);
        applyStimulus({8'd0, 8'd1, 8'd2});
        drainRun(100, 6, 1'b0, "after_reset");

`ifdef LOOP_NEST_COUNTER_ABORT_EN
        $display("[TB] abort at beat 5");
        pushSequence({8'd1, 8'd2, 8'd3}, 5);
        abort = 1'b1;
        applyStimulus({8'd1, 8'd2, 8'd3});
        abort     = 1'b0;
        out_ready = 1'b1;
        stopped   = 1'b0;
        for (int c = 0; c < 100 && !stopped; c++) begin
            abort = (sbQ.size() == 1);
            @(posedge clk);
            #1;
            abort   = 1'b0;
            stopped = (sbQ.size() == 0);
        end
        out_ready = 1'b0;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("abort_out_idx", 64'(out_idx), 64'd0);
        pushSequence({8'd0, 8'd0, 8'd1}, 0);
        applyStimulus({8'd0, 8'd0, 8'd1});
        drainRun(100, 2, 1'b0, "after_abort");
`endif

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
